cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, carry-pipelined adder/subtractor built from 16-bit carry look-ahead segments, each a 4-bit CLA group array with a lookahead carry unit. It extends the combinational 16-bit CLA to arbitrary multiples of 16 bits and adds a subtract mode, status flags and a valid/ready stream interface. One result per cycle at full throughput. It sits in the datapath as the shared wide-integer add/sub unit.

## Interface
- WIDTH, 32: operand width; must be a multiple of 16, at least 16. NSEG = WIDTH/16.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A (unsigned or two's complement)
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in for add; ignored for sub
- in_sub  input  1  0 = A+B+cin, 1 = A-B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result, modulo 2^WIDTH
- out_cout  output  1  carry out of MSB; for sub, 1 = no borrow (A >= B unsigned)
- out_ovf  output  1  signed overflow
- out_zero  output  1  out_sum == 0

## Operation
- Sub: effective B = ~in_b, effective carry-in = 1. Add: B = in_b, carry-in = in_cin.
- Pipeline of NSEG stages. Stage k (k = 1..NSEG) computes segment k-1 (bits 16k-1..16k-16) with one 16-bit CLA/LCU, using the carry registered from stage k-1. Stage 1 uses the effective carry-in.
- Higher operand segments travel in skew registers. Completed lower sum segments travel in deskew registers, so each stage carries only what is still needed.
- Each stage has a valid bit. All stages advance together when adv = !out_valid || out_ready. On adv, stage k loads stage k-1, and stage 1 loads the input beat with valid = in_valid.
- in_ready = adv. This is combinational from out_valid and out_ready, with no dependence on in_valid.
- A beat is accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
- Bubbles are not compressed. An empty stage still waits for adv.
- Flags are computed in the final stage from the final segment:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = NOR of all WIDTH sum bits.
- No control FSM. Control is per-stage valid bits only.

## Timing
- Reset, asynchronous on rst_n low:
  - All valid bits cleared; out_valid = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - All skew and carry registers cleared. in_ready = 1 while out_valid = 0.
- Reset mid-operation discards every in-flight beat. No output is produced for those beats.
- Latency: a beat accepted at clock edge E appears with out_valid = 1 after edge E+NSEG-1, i.e. NSEG cycles. WIDTH=32 gives 2 cycles. WIDTH=16 gives 1 cycle, a single registered stage.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, every stage and all outputs hold and in_ready = 0. Operand changes on the input while in_ready = 0 have no effect.
- Simultaneous output transfer and input accept in the same cycle is legal and required at full rate.
- Results leave in acceptance order. No beat is dropped or duplicated.
- Outputs are stable while out_valid && !out_ready.

## Test plan
- Add, WIDTH=32: A=30037, B=30049, sub=0, cin=0 -> out_sum=60086, cout=0, ovf=0, zero=0, exactly 2 cycles after acceptance.
- Wrap: A=0xFFFFFFFF, B=0, cin=1 -> sum=0x00000000, cout=1, zero=1, ovf=0. Also A=0x7FFFFFFF, B=1 -> sum=0x80000000, ovf=1, cout=0. The inter-segment carry must propagate across the pipeline register.
- Subtract: A=462, B=391, sub=1, cin=1 (ignored) -> sum=71, cout=1. Swap operands -> sum=0xFFFFFFB9, cout=0, ovf=0.
- Streaming with backpressure: 8 random beats on consecutive cycles, out_ready low for 3 cycles mid-stream. Required: in_ready low during the stall, outputs held, all 8 results in order and matching a reference model, no loss or duplication.
- Reset mid-flight: accept 2 beats, assert rst_n low for 1 cycle before either emerges. Required: out_valid=0 and all outputs 0 immediately, no result for those beats afterwards. A subsequent beat 5+6 -> 11 after 2 cycles.
- Parameter sweep: WIDTH=16 (latency 1, 65535+65535 -> 65534, cout=1) and WIDTH=64 (latency 4, random add/sub against a reference model).

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Carry-pipelined WIDTH-bit adder/subtractor built from 16-bit CLA segments, one segment per stage,
// with a valid/ready stream interface and carry/overflow/zero flags on the result.
module cla_pipe_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NSEG = WIDTH / 16;

    logic             adv;
    logic [WIDTH-1:0] bEff;
    logic             cEff;

    // 16-bit CLA: four 4-bit lookahead groups joined by a lookahead carry unit. Returns {cout, sum}.
    function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[4], p ^ c};
    endfunction

    assign bEff = in_sub ? ~in_b : in_b;
    assign cEff = in_sub | in_cin;

    genvar s;
    generate
        for (s = 0; s < NSEG; s = s + 1) begin : g_stage
            localparam int SW = 16 * (s + 1);
            localparam int RW = WIDTH - 16 * s;

            logic [RW-1:0] remA;
            logic [RW-1:0] remB;
            logic          carryIn;
            logic          validIn;
            logic [16:0]   claRes;
            logic [SW-1:0] sumD;
            logic [SW-1:0] sumQ;
            logic          validQ;
            logic          carryQ;

            // Operands not yet consumed arrive from the skew registers; finished low segments ride along below.
            if (s == 0) begin : g_src
                assign remA    = in_a;
                assign remB    = bEff;
                assign carryIn = cEff;
                assign validIn = in_valid;
                assign sumD    = claRes[15:0];
            end else begin : g_src
                assign remA    = g_stage[s-1].g_skew.aQ;
                assign remB    = g_stage[s-1].g_skew.bQ;
                assign carryIn = g_stage[s-1].carryQ;
                assign validIn = g_stage[s-1].validQ;
                assign sumD    = {claRes[15:0], g_stage[s-1].sumQ};
            end

            assign claRes = cla16(remA[15:0], remB[15:0], carryIn);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    validQ <= 1'b0;
                    carryQ <= 1'b0;
                    sumQ   <= '0;
                end else if (adv) begin
                    validQ <= validIn;
                    carryQ <= claRes[16];
                    sumQ   <= sumD;
                end
            end

            if (s < NSEG - 1) begin : g_skew
                logic [RW-17:0] aQ;
                logic [RW-17:0] bQ;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        aQ <= '0;
                        bQ <= '0;
                    end else if (adv) begin
                        aQ <= remA[RW-1:16];
                        bQ <= remB[RW-1:16];
                    end
                end
            end else begin : g_flags
                logic ovfQ;
                logic zeroQ;

                // Carry into the MSB is recovered from its sum bit: c15 = s15 ^ a15 ^ b15.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovfQ  <= 1'b0;
                        zeroQ <= 1'b0;
                    end else if (adv) begin
                        ovfQ  <= claRes[16] ^ claRes[15] ^ remA[15] ^ remB[15];
                        zeroQ <= ~|sumD;
                    end
                end
            end
        end
    endgenerate

    assign adv       = ~g_stage[NSEG-1].validQ | out_ready;
    assign in_ready  = adv;
    assign out_valid = g_stage[NSEG-1].validQ;
    assign out_sum   = g_stage[NSEG-1].sumQ;
    assign out_cout  = g_stage[NSEG-1].carryQ;
    assign out_ovf   = g_stage[NSEG-1].g_flags.ovfQ;
    assign out_zero  = g_stage[NSEG-1].g_flags.zeroQ;

endmodule
